sparse_batch_accum: RTL and testbench

Consumes a sparse stream of (neuron, weight, index) triples from the PE array. Accumulates signed products into 2^IDX_W indexed RES_W accumulators over BATCH samples. Then drains the accumulators serially to the gradient buffer.
Sits directly upstream of the gradient buffer. Shares DATA_W, RES_W, IDX_W and BATCH with the global parameter package.

---
 rtl/sparse_batch_accum_pkg.sv | 25 ++
 rtl/sparse_batch_accum_mac_stage.sv | 63 ++++++
 rtl/sparse_batch_accum.sv | 149 ++++++++++++++
 tb/tb_sparse_batch_accum.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sparse_batch_accum_pkg.sv
// Shared parameters, width helper and FSM state type for the sparse batch accumulator.
// The optional saturating accumulation is enabled with the GLB_ACC_SAT_EN macro.
package sparse_batch_accum_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 32;
  localparam int IDX_W  = 4;
  localparam int BATCH  = 32;

  // Bits needed to encode values 0..v-1 (never less than one bit).
  function automatic int bw(input int v);
    if (v <= 2) begin
      return 1;
    end else begin
      return $clog2(v);
    end
  endfunction

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sparse_batch_accum_mac_stage.sv
// sparse_mac_stage: registered signed multiply followed by sign-extend and accumulate add.
// With GLB_ACC_SAT_EN the add clamps to the signed RES_W range and reports saturation.
module sparse_mac_stage #(
  parameter int DATA_W = sparse_batch_accum_pkg::DATA_W,
  parameter int RES_W  = sparse_batch_accum_pkg::RES_W,
  parameter int IDX_W  = sparse_batch_accum_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [RES_W-1:0]  acc_cur,
  output logic              s1_valid,
  output logic [IDX_W-1:0]  s1_idx,
  output logic [RES_W-1:0]  acc_new
`ifdef GLB_ACC_SAT_EN
  , output logic            sat
`endif
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [RES_W-1:0]    prod_ext;

  // Stage 1: capture the product and its target index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      prod     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        prod   <= $signed(in_data) * $signed(in_weight);
        s1_idx <= in_idx;
      end
    end
  end

  assign prod_ext = RES_W'(prod);

`ifdef GLB_ACC_SAT_EN
  logic [RES_W:0] wide;
  logic           ovf;

  assign wide = {acc_cur[RES_W-1], acc_cur} + {prod_ext[RES_W-1], prod_ext};
  assign ovf  = (wide[RES_W] != wide[RES_W-1]);
  assign sat  = s1_valid & ovf;

  // Stage 2: clamp toward the sign of the true (RES_W+1)-bit sum on overflow.
  always_comb begin
    if (ovf) begin
      acc_new = wide[RES_W] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
    end else begin
      acc_new = wide[RES_W-1:0];
    end
  end
`else
  assign acc_new = acc_cur + prod_ext;
`endif

endmodule

// File: rtl/sparse_batch_accum.sv
// Sparse batch accumulator: accumulates signed products into 2**IDX_W slots over BATCH samples,
// then drains the slots in index order. GLB_ACC_SAT_EN adds saturation and a sticky sat_flag.
module sparse_batch_accum #(
  parameter int DATA_W = sparse_batch_accum_pkg::DATA_W,
  parameter int RES_W  = sparse_batch_accum_pkg::RES_W,
  parameter int IDX_W  = sparse_batch_accum_pkg::IDX_W,
  parameter int BATCH  = sparse_batch_accum_pkg::BATCH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [sparse_batch_accum_pkg::bw(BATCH+1)-1:0] sample_cnt
`ifdef GLB_ACC_SAT_EN
  , output logic            sat_flag
`endif
);

  import sparse_batch_accum_pkg::*;

  localparam int NACC  = 2**IDX_W;
  localparam int CNT_W = sparse_batch_accum_pkg::bw(BATCH+1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               in_ready_nxt;
  logic               accept, handshake;
  logic               s1_valid;
  logic [IDX_W-1:0]   s1_idx;
  logic [RES_W-1:0]   acc_new;
  logic [RES_W-1:0]   acc [NACC];

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  // Drain outputs come straight from registers so reset clears them immediately.
  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? acc[ptr] : '0;
  assign out_idx   = out_valid ? ptr : '0;
  assign out_last  = out_valid & (&ptr);

`ifdef GLB_ACC_SAT_EN
  logic sat;

  sparse_mac_stage #(.DATA_W(DATA_W), .RES_W(RES_W), .IDX_W(IDX_W)) u_mac (
    .clk(clk), .rst(rst), .accept(accept),
    .in_data(in_data), .in_weight(in_weight), .in_idx(in_idx),
    .acc_cur(acc[s1_idx]), .s1_valid(s1_valid), .s1_idx(s1_idx),
    .acc_new(acc_new), .sat(sat)
  );

  // Sticky saturation flag, cleared when the final drain word is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (handshake && out_last) begin
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= sat_flag | sat;
    end
  end
`else
  sparse_mac_stage #(.DATA_W(DATA_W), .RES_W(RES_W), .IDX_W(IDX_W)) u_mac (
    .clk(clk), .rst(rst), .accept(accept),
    .in_data(in_data), .in_weight(in_weight), .in_idx(in_idx),
    .acc_cur(acc[s1_idx]), .s1_valid(s1_valid), .s1_idx(s1_idx),
    .acc_new(acc_new)
  );
`endif

  // Next-state, drain pointer and sample counter logic.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = sample_cnt;
    case (state)
      ACCUM: begin
        if (accept && in_last) begin
          cnt_nxt = sample_cnt + 1'b1;
          if (cnt_nxt == CNT_W'(BATCH)) begin
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Only stage 1 can hold work; stage 2 retires on the same edge.
        if (!s1_valid) begin
          state_nxt = DRAIN;
          ptr_nxt   = '0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          ptr_nxt = ptr + 1'b1;
          if (&ptr) begin
            state_nxt = ACCUM;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
    in_ready_nxt = (state_nxt == ACCUM);
  end

  // Control registers; in_ready is registered so it is low during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      ptr        <= '0;
      sample_cnt <= '0;
      in_ready   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      sample_cnt <= cnt_nxt;
      in_ready   <= in_ready_nxt;
    end
  end

  // Accumulator array: stage-2 write-back, and clear-on-read while draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NACC; i++) begin
        acc[i] <= '0;
      end
    end else begin
      if (s1_valid) begin
        acc[s1_idx] <= acc_new;
      end
      if (handshake) begin
        acc[ptr] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sparse_batch_accum.sv
// Randomized self-checking bench for sparse_batch_accum (RES_W=16 so overflow is reachable);
// a per-index integer model tracks expected accumulator contents. Honors GLB_ACC_SAT_EN.
module tb_sparse_batch_accum;

  localparam int TB_RES_W = 16;
  localparam int TB_NACC  = 16;
  localparam int TB_BATCH = 32;
  localparam longint FULL = 64'sd1 << TB_RES_W;
  localparam longint HALF = 64'sd1 << (TB_RES_W - 1);

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid, in_ready, in_last;
  logic [7:0]          in_data, in_weight;
  logic [3:0]          in_idx;
  logic                out_valid, out_ready, out_last;
  logic [TB_RES_W-1:0] out_data;
  logic [3:0]          out_idx;
  logic [5:0]          sample_cnt;
`ifdef GLB_ACC_SAT_EN
  logic                sat_flag;
`endif

  sparse_batch_accum #(.RES_W(TB_RES_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_weight(in_weight), .in_idx(in_idx), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .sample_cnt(sample_cnt)
`ifdef GLB_ACC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int     errors = 0;
  int     checks = 0;
  longint model [TB_NACC];
  bit     model_sat;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: exact sum, then wrap or clamp to the signed result range.
  task automatic model_add(input int idx, input longint p);
    longint v;
    v = model[idx] + p;
`ifdef GLB_ACC_SAT_EN
    if (v > HALF - 1) begin
      v = HALF - 1;
      model_sat = 1'b1;
    end else if (v < -HALF) begin
      v = -HALF;
      model_sat = 1'b1;
    end
`else
    v = v % FULL;
    if (v < 0) v += FULL;
    if (v >= HALF) v -= FULL;
`endif
    model[idx] = v;
  endtask

  task automatic model_clear();
    for (int i = 0; i < TB_NACC; i++) model[i] = 0;
    model_sat = 1'b0;
  endtask

  task automatic send(input int d, input int w, input int idx, input bit last);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'(d);
    in_weight = 8'(w);
    in_idx    = 4'(idx);
    in_last   = last;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_add(idx, longint'(d * w));
    end
  endtask

  function automatic int rnd_s8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic random_batch();
    for (int s = 0; s < TB_BATCH; s++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int t = 0; t < n; t++)
        send(rnd_s8(), rnd_s8(), int'($urandom_range(0, 15)), t == n - 1);
    end
  endtask

  // After the closing sample: keep offering a triple; it must not be taken.
  task automatic hold_after_batch();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd9; in_weight = 8'd9; in_idx = 4'd3; in_last = 1'b1;
    check("cnt_full", longint'(sample_cnt), TB_BATCH);
    for (int i = 0; i < 6; i++) begin
      check("ready_low_full", longint'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n_hs, input bit rand_ready);
    int hs, cyc;
    hs = 0;
    cyc = 0;
    while (hs < n_hs && cyc < 300) begin
      @(negedge clk);
      cyc++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        check("drain_idx", longint'(out_idx), hs);
        check("drain_data", longint'($signed(out_data)), model[hs]);
        check("drain_last", longint'(out_last), longint'(hs == TB_NACC - 1));
`ifdef GLB_ACC_SAT_EN
        check("sat_flag", longint'(sat_flag), longint'(model_sat));
`endif
        if (out_ready) begin
          @(posedge clk);
          model[hs] = 0;
          hs++;
        end
      end
    end
    check("handshakes", hs, n_hs);
    @(negedge clk);
    out_ready = 1'b0;
    if (n_hs == TB_NACC) begin
      model_sat = 1'b0;
      check("post_valid", longint'(out_valid), 0);
      check("post_cnt", longint'(sample_cnt), 0);
      check("post_ready", longint'(in_ready), 1);
`ifdef GLB_ACC_SAT_EN
      check("post_sat", longint'(sat_flag), 0);
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_weight = '0; in_idx = '0; in_last = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_ready", longint'(in_ready), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_data", longint'(out_data), 0);
    check("rst_cnt", longint'(sample_cnt), 0);
    rst = 1'b0;

    // Two products into one slot per sample.
    for (int s = 0; s < TB_BATCH; s++) begin
      send(3, 4, 2, 1'b0);
      send(-5, 6, 2, 1'b1);
    end
    hold_after_batch();
    drain(TB_NACC, 1'b0);

    // Back-to-back same index, drained with a stalling consumer.
    for (int s = 0; s < TB_BATCH; s++)
      for (int t = 0; t < 8; t++) send(1, 1, 7, t == 7);
    hold_after_batch();
    drain(TB_NACC, 1'b1);

    random_batch();
    hold_after_batch();
    drain(TB_NACC, 1'b1);

    // Overflow in slot 0, then empty samples (zero products still count).
    for (int t = 0; t < 5; t++) send(127, 127, 0, t == 4);
    for (int s = 1; s < TB_BATCH; s++) send(0, rnd_s8(), int'($urandom_range(1, 15)), 1'b1);
    hold_after_batch();
    drain(TB_NACC, 1'b0);

    // Reset in the middle of a drain, then a fresh batch.
    random_batch();
    hold_after_batch();
    drain(5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_data", longint'(out_data), 0);
    check("mid_rst_idx", longint'(out_idx), 0);
    check("mid_rst_last", longint'(out_last), 0);
    check("mid_rst_ready", longint'(in_ready), 0);
    check("mid_rst_cnt", longint'(sample_cnt), 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    random_batch();
    hold_after_batch();
    drain(TB_NACC, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
